// File: rtl/axi3_slave_mem_model.sv
// rtl/axi3_slave_mem_model.sv - AXI3 slave memory model terminating the accelerator's 64-bit master port
module axi3_slave_mem_model #(
    parameter int ID_W       = 6,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int MEM_ADDR_W = 12,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ID_W-1:0]       S_AXI_AWID,
    input  logic [ADDR_W-1:0]     S_AXI_AWADDR,
    input  logic [3:0]            S_AXI_AWLEN,
    input  logic [1:0]            S_AXI_AWBURST,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [ID_W-1:0]       S_AXI_WID,
    input  logic [DATA_W-1:0]     S_AXI_WDATA,
    input  logic [DATA_W/8-1:0]   S_AXI_WSTRB,
    input  logic                  S_AXI_WLAST,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [ID_W-1:0]       S_AXI_BID,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ID_W-1:0]       S_AXI_ARID,
    input  logic [ADDR_W-1:0]     S_AXI_ARADDR,
    input  logic [3:0]            S_AXI_ARLEN,
    input  logic [1:0]            S_AXI_ARBURST,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [ID_W-1:0]       S_AXI_RID,
    output logic [DATA_W-1:0]     S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RLAST,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic [31:0]           rd_beat_count,
    output logic [31:0]           wr_beat_count
);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    localparam logic [3:0] RD_LAT = 4'(RD_LATENCY);

    logic [DATA_W-1:0] mem [0:(2**MEM_ADDR_W)-1];

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{S_AXI_AWADDR[2:0], S_AXI_AWADDR[ADDR_W-1:MEM_ADDR_W+3],
                                S_AXI_ARADDR[2:0], S_AXI_ARADDR[ADDR_W-1:MEM_ADDR_W+3]};

    // Keeps every READY/VALID low for one extra cycle after reset is released.
    logic init_done;
    logic out_en;
    always_ff @(posedge clk) begin
        if (reset) init_done <= 1'b0;
        else       init_done <= 1'b1;
    end
    assign out_en = init_done && !reset;

    // ---------------------------------------------------------------- read path
    r_state_t              r_state, r_state_next;
    logic [3:0]            r_cnt;
    logic [ID_W-1:0]       r_id;
    logic [MEM_ADDR_W-1:0] r_idx;
    logic [3:0]            r_len;
    logic [3:0]            r_beat;
    logic                  r_ok;
    logic                  rvalid_q;
    logic                  rlast_q;
    logic [DATA_W-1:0]     rdata_q;
    logic [31:0]           rd_cnt;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  r_load;

    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_hs  = S_AXI_RVALID && S_AXI_RREADY;

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_state_next;
    end

    // Read FSM next state: latency countdown, then stream beats until RLAST is taken.
    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_next = (RD_LAT == 4'd0) ? R_DATA : R_WAIT;
            R_WAIT:  if (r_cnt == 4'd1) r_state_next = R_DATA;
            R_DATA:  if (r_hs && rlast_q) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Read outputs; a new beat is fetched when the R register is empty or being drained mid-burst.
    always_comb begin
        S_AXI_ARREADY = out_en && (r_state == R_IDLE);
        S_AXI_RVALID  = out_en && rvalid_q;
        S_AXI_RLAST   = S_AXI_RVALID && rlast_q;
        S_AXI_RRESP   = (S_AXI_RVALID && !r_ok) ? 2'b10 : 2'b00;
        S_AXI_RID     = r_id;
        S_AXI_RDATA   = rdata_q;
        r_load        = out_en && (r_state == R_DATA) &&
                        (!rvalid_q || (S_AXI_RREADY && !rlast_q));
    end

    // Read datapath: burst context, registered RAM read, beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= 4'd0;
            r_id     <= '0;
            r_idx    <= '0;
            r_len    <= 4'd0;
            r_beat   <= 4'd0;
            r_ok     <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rdata_q  <= '0;
            rd_cnt   <= 32'd0;
        end else begin
            if (ar_hs) begin
                r_id   <= S_AXI_ARID;
                r_idx  <= S_AXI_ARADDR[MEM_ADDR_W+2:3];
                r_len  <= S_AXI_ARLEN;
                r_beat <= 4'd0;
                r_ok   <= (S_AXI_ARBURST == 2'b01);
                r_cnt  <= RD_LAT;
            end else if (r_state == R_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_load) begin
                rdata_q  <= mem[r_idx];
                rlast_q  <= (r_beat == r_len);
                r_idx    <= r_idx + 1'b1;
                r_beat   <= r_beat + 4'd1;
                rvalid_q <= 1'b1;
            end else if (r_hs) begin
                rvalid_q <= 1'b0;
            end
            if (r_hs) rd_cnt <= rd_cnt + 32'd1;
        end
    end

    assign rd_beat_count = rd_cnt;

    // --------------------------------------------------------------- write path
    w_state_t              w_state, w_state_next;
    logic [ID_W-1:0]       w_id;
    logic [MEM_ADDR_W-1:0] w_idx;
    logic [3:0]            w_len;
    logic [3:0]            w_beat;
    logic                  w_ok;
    logic                  w_err;
    logic [31:0]           wr_cnt;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  b_hs;
    logic                  w_final;

    assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
    assign b_hs    = S_AXI_BVALID && S_AXI_BREADY;
    assign w_final = S_AXI_WLAST || (w_beat == w_len);

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_state_next;
    end

    // Write FSM next state: burst ends on WLAST or beat LEN, whichever comes first.
    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_next = W_DATA;
            W_DATA:  if (w_hs && w_final) w_state_next = W_RESP;
            W_RESP:  if (b_hs) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    // Write channel handshakes and B response.
    always_comb begin
        S_AXI_AWREADY = out_en && (w_state == W_IDLE);
        S_AXI_WREADY  = out_en && (w_state == W_DATA);
        S_AXI_BVALID  = out_en && (w_state == W_RESP);
        S_AXI_BRESP   = (S_AXI_BVALID && (w_err || !w_ok)) ? 2'b10 : 2'b00;
        S_AXI_BID     = w_id;
    end

    // Write datapath: burst context, protocol error flag, beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_id   <= '0;
            w_idx  <= '0;
            w_len  <= 4'd0;
            w_beat <= 4'd0;
            w_ok   <= 1'b0;
            w_err  <= 1'b0;
            wr_cnt <= 32'd0;
        end else begin
            if (aw_hs) begin
                w_id   <= S_AXI_AWID;
                w_idx  <= S_AXI_AWADDR[MEM_ADDR_W+2:3];
                w_len  <= S_AXI_AWLEN;
                w_beat <= 4'd0;
                w_ok   <= (S_AXI_AWBURST == 2'b01);
                w_err  <= 1'b0;
            end
            if (w_hs) begin
                w_idx  <= w_idx + 1'b1;
                w_beat <= w_beat + 4'd1;
                wr_cnt <= wr_cnt + 32'd1;
                if ((S_AXI_WID != w_id) ||
                    (S_AXI_WLAST && (w_beat != w_len)) ||
                    ((w_beat == w_len) && !S_AXI_WLAST))
                    w_err <= 1'b1;
            end
        end
    end

    assign wr_beat_count = wr_cnt;

    // RAM byte-lane commit; contents survive reset and unsupported bursts write nothing.
    always_ff @(posedge clk) begin
        if (w_hs && w_ok) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (S_AXI_WSTRB[b]) mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

endmodule

// File: doc/axi3_slave_mem_model.md
Name: axi3_slave_mem_model

Overview:
- AXI3 slave memory model that terminates the 64-bit master port of the DNN accelerator.
- Sits directly downstream of the accelerator's M_AXI_* interface, in place of tie-offs, in simulation and synthesis tops.
- Serves read bursts from a word-addressed internal RAM and commits write bursts with byte strobes.
- Handles one outstanding read and one outstanding write independently; read and write channels run concurrently.

Parameters:
- ID_W, 6, AXI ID width for AWID, WID, BID, ARID and RID.
- ADDR_W, 32, AXI byte-address width.
- DATA_W, 64, AXI data width; fixed at 64 (8 strobe bits).
- MEM_ADDR_W, 12, log2 of RAM depth in 64-bit words.
- RD_LATENCY, 2, idle cycles between AR handshake and first R beat (0..15).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- S_AXI_AWID  in  ID_W  write ID
- S_AXI_AWADDR  in  ADDR_W  write start byte address
- S_AXI_AWLEN  in  4  write beats minus 1
- S_AXI_AWBURST  in  2  burst type
- S_AXI_AWVALID  in  1  AW valid
- S_AXI_AWREADY  out  1  AW ready
- S_AXI_WID  in  ID_W  write data ID
- S_AXI_WDATA  in  64  write data
- S_AXI_WSTRB  in  8  byte enables
- S_AXI_WLAST  in  1  last write beat
- S_AXI_WVALID  in  1  W valid
- S_AXI_WREADY  out  1  W ready
- S_AXI_BID  out  ID_W  response ID
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID  out  1  B valid
- S_AXI_BREADY  in  1  B ready
- S_AXI_ARID  in  ID_W  read ID
- S_AXI_ARADDR  in  ADDR_W  read start byte address
- S_AXI_ARLEN  in  4  read beats minus 1
- S_AXI_ARBURST  in  2  burst type
- S_AXI_ARVALID  in  1  AR valid
- S_AXI_ARREADY  out  1  AR ready
- S_AXI_RID  out  ID_W  read ID
- S_AXI_RDATA  out  64  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RLAST  out  1  last read beat
- S_AXI_RVALID  out  1  R valid
- S_AXI_RREADY  in  1  R ready
- rd_beat_count  out  32  total R beats handshaken since reset
- wr_beat_count  out  32  total W beats handshaken since reset

Behaviour:
- Clocking and reset: clk; reset is synchronous, active-high.
- Outputs during reset and on the first cycle after: all outputs 0, including the READYs. RAM contents are not reset.
- Word index: addr[MEM_ADDR_W+2:3]. Upper bits are ignored, so addresses alias modulo RAM size. Within a burst the index increments by 1 per beat and wraps from all-ones to 0. AxSIZE is ignored; 8 bytes per beat.
- AxLOCK, AxCACHE, AxPROT and AxQOS are not ported; the top leaves those master outputs unconnected.
- Read FSM, R_IDLE: ARREADY=1. On ARVALID&&ARREADY, latch ID, index, LEN and burst-ok (ARBURST==2'b01). Go to R_WAIT with counter=RD_LATENCY, or straight to R_DATA if RD_LATENCY==0.
- Read FSM, R_WAIT: ARREADY=0. Decrement the counter; enter R_DATA when it reaches 0.
- First R beat timing: if the AR handshake is at edge t, RVALID is first high in the cycle after edge t+1+RD_LATENCY.
- Read FSM, R_DATA: RVALID=1 and RID=latched ID. RDATA is a registered RAM read of the current index. RRESP is 2'b00, or 2'b10 (SLVERR) when burst-ok=0 (data is still returned). RLAST=1 on beat LEN.
- R_DATA holds all R outputs stable while RREADY=0. On RVALID&&RREADY, advance the beat. After the last beat go to R_IDLE, with RVALID=0 in the next cycle.
- Write FSM, W_IDLE: AWREADY=1, WREADY=0. On AW handshake, latch ID, index, LEN and burst-ok, clear the error flag, and go to W_DATA.
- Write FSM, W_DATA: WREADY=1. On each W handshake:
  - Write each byte whose WSTRB bit is set, but only if burst-ok=1.
  - Set the error flag if WID!=latched ID, if WLAST is asserted on a beat other than LEN, or if beat LEN arrives with WLAST=0.
- Leaving W_DATA: the burst terminates on WLAST or on beat LEN, whichever comes first, then go to W_RESP. Beats beyond LEN are never accepted.
- Write FSM, W_RESP: BVALID=1, BID=latched ID, BRESP=2'b10 if the error flag is set or burst-ok=0, else 2'b00. Hold until BREADY, then return to W_IDLE.
- Same-word collision: if a write commits at the same edge that RDATA is loaded for that word, RDATA returns the old data.
- Counters: rd_beat_count and wr_beat_count increment by 1 per handshake and wrap at 2^32.
- Reset mid-burst: both FSMs return to idle, counters clear, no B or R is issued for the aborted bursts, and any writes already committed stay.

Test Plan:
- Write then read back: AW addr 0x40, LEN=3, INCR, data 0x11..0x44, WSTRB=0xFF, then AR same address -> BRESP=00; R beats 0x11,0x22,0x33,0x44 with RLAST only on beat 3; first RVALID 3 cycles after AR handshake (RD_LATENCY=2).
- Partial strobe: word 0 preloaded with 0xFFFF_FFFF_FFFF_FFFF, write 0 with WSTRB=0x0F -> readback 0xFFFF_FFFF_0000_0000.
- Backpressure: RREADY toggling 1,0,0,1 per cycle -> R outputs stable while stalled; rd_beat_count increments only on handshakes.
- Protocol errors: early WLAST on beat 1 of a LEN=3 burst -> BRESP=10 after beat 1. ARBURST=00 -> RRESP=10 on every beat, all LEN+1 beats delivered.
- Wrap and alias: MEM_ADDR_W=12, write to 0x7FF8 with LEN=1 -> second beat lands at index 0; reading at 0x8000 returns it.
- Concurrency and reset: read and write bursts issued simultaneously both complete; reset asserted mid-read -> RVALID=0 and ARREADY=0 on the first post-reset cycle, ARREADY=1 on the next.
